// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and defaults for the mux select scanner.
// MUX_SCAN_CHANGE_EN (optional) adds the per-sweep change vector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_IN_DEFAULT  = 4;
  localparam int unsigned DWELL_DEFAULT = 4;

  // Select/counter width; a single-value range still needs one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Scanner <-> control/mux signal bundle.
// MUX_SCAN_CHANGE_EN adds the change vector to the bundle.
interface mux_sel_scanner_if #(
  parameter int unsigned N_IN = mux_scan_pkg::N_IN_DEFAULT
) ();
  import mux_scan_pkg::*;

  localparam int unsigned SEL_W = sel_w(N_IN);

  logic             start;
  logic             mux_out;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N_IN-1:0]  sample;
`ifdef MUX_SCAN_CHANGE_EN
  logic [N_IN-1:0]  change;

  modport master (
    input  start, mux_out,
    output sel, busy, done, sample, change
  );

  modport slave (
    output start, mux_out,
    input  sel, busy, done, sample, change
  );
`else
  modport master (
    input  start, mux_out,
    output sel, busy, done, sample
  );

  modport slave (
    output start, mux_out,
    input  sel, busy, done, sample
  );
`endif

endinterface

// File: rtl/mux_sel_scanner_dwell_counter.sv
// Loadable count-up dwell counter; flags the last clock of a dwell.
module dwell_counter #(
  parameter int unsigned DWELL = mux_scan_pkg::DWELL_DEFAULT,
  parameter int unsigned CNT_W = mux_scan_pkg::sel_w(DWELL)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = en && (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_sel_scanner.sv
// Steps the mux select through every input, samples each at the end of its dwell,
// and publishes one snapshot per sweep. MUX_SCAN_CHANGE_EN adds a change vector.
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_IN       = N_IN_DEFAULT,
  parameter int unsigned DWELL      = DWELL_DEFAULT,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_scanner_if.master    bus
);

  localparam int unsigned SEL_W = sel_w(N_IN);
  localparam int unsigned CNT_W = sel_w(DWELL);
  localparam bit          AUTO  = (CONTINUOUS != 0);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  shadow_q, shadow_d;
  logic [N_IN-1:0]  sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_c;
`ifdef MUX_SCAN_CHANGE_EN
  logic [N_IN-1:0]  change_q, change_d;
`endif

  // Counter is held at zero outside SCAN and restarts at each dwell boundary.
  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state_q != SCAN) || tc_c),
    .en    (state_q == SCAN),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
      change_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MUX_SCAN_CHANGE_EN
      change_q <= change_d;
`endif
    end
  end

  // Next state; sample takes the completed shadow including the bit captured this edge.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    done_d   = 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
    change_d = change_q;
`endif
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start || AUTO) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tc_c) begin
          shadow_d[sel_q] = bus.mux_out;
          if (sel_q == SEL_W'(N_IN - 1)) begin
            state_d  = DONE;
            sample_d = shadow_d;
            done_d   = 1'b1;
`ifdef MUX_SCAN_CHANGE_EN
            change_d = shadow_d ^ sample_q;
`endif
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = (bus.start || AUTO) ? SCAN : IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;
`ifdef MUX_SCAN_CHANGE_EN
  assign bus.change = change_q;
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Randomized self-checking bench: one-shot and continuous scanners against a sweep-level model.
module tb_mux_sel_scanner;

  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int SWEEP = N * DWELL;

  typedef struct {
    bit         active;
    bit         indone;
    bit         done;
    int         t;
    logic [3:0] shadow;
    logic [3:0] sample;
    logic [3:0] change;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] in_v = 4'b0;
  logic [3:0] in_c = 4'b0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_c = -1;

  mstate_t m_main, m_cont;

  mux_sel_scanner_if #(.N_IN(N)) bus ();
  mux_sel_scanner_if #(.N_IN(N)) bus_c ();

  assign bus.start     = start;
  assign bus.mux_out   = in_v[bus.sel];
  assign bus_c.start   = 1'b0;
  assign bus_c.mux_out = in_c[bus_c.sel];

  mux_sel_scanner #(.N_IN(N), .DWELL(DWELL), .CONTINUOUS(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_sel_scanner #(.N_IN(N), .DWELL(DWELL), .CONTINUOUS(1)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  logic [3:0] ch_main, ch_cont;
`ifdef MUX_SCAN_CHANGE_EN
  assign ch_main = bus.change;
  assign ch_cont = bus_c.change;
`else
  assign ch_main = 4'b0;
  assign ch_cont = 4'b0;
`endif

  always #5 clk = ~clk;

  function automatic mstate_t mreset();
    mstate_t r;
    r.active = 1'b0; r.indone = 1'b0; r.done = 1'b0; r.t = 0;
    r.shadow = 4'b0; r.sample = 4'b0; r.change = 4'b0;
    return r;
  endfunction

  // One clock of the sweep: t counts clocks into the sweep, input t/DWELL is
  // captured on the last clock of its dwell, and a sweep ends after N*DWELL clocks.
  function automatic mstate_t mstep(mstate_t m, bit go, logic [3:0] in);
    mstate_t r = m;
    int idx;
    r.done = 1'b0;
    if (m.indone) begin
      r.indone = 1'b0;
      r.active = go;
      r.t      = 0;
    end else if (!m.active) begin
      if (go) begin
        r.active = 1'b1;
        r.t      = 0;
      end
    end else begin
      idx = m.t / DWELL;
      if ((m.t % DWELL) == DWELL - 1) r.shadow[idx] = in[idx];
      r.t = m.t + 1;
      if (r.t == SWEEP) begin
        r.active = 1'b0;
        r.indone = 1'b1;
        r.done   = 1'b1;
        r.change = r.shadow ^ m.sample;
        r.sample = r.shadow;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic check_dut(input string tag, input mstate_t m, input logic [1:0] sel,
                           input logic busy, input logic done, input logic [3:0] sample,
                           input logic [3:0] change);
    if (!m.indone) chk({tag, ".sel"}, 32'(sel), m.active ? 32'(m.t / DWELL) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(m.active || m.indone));
    chk({tag, ".done"}, 32'(done), 32'(m.done));
    chk({tag, ".sample"}, 32'(sample), 32'(m.sample));
`ifdef MUX_SCAN_CHANGE_EN
    chk({tag, ".change"}, 32'(change), 32'(m.change));
`else
    if (change !== 4'b0) chk({tag, ".change_tie"}, 32'(change), 32'd0);
`endif
  endtask

  task automatic check_reset_now();
    chk("rst.sel",    32'(bus.sel),    32'd0);
    chk("rst.busy",   32'(bus.busy),   32'd0);
    chk("rst.done",   32'(bus.done),   32'd0);
    chk("rst.sample", 32'(bus.sample), 32'd0);
    chk("rst_c.busy", 32'(bus_c.busy), 32'd0);
    chk("rst_c.sample", 32'(bus_c.sample), 32'd0);
  endtask

  // Model advance: async reset, otherwise one step per rising edge.
  initial begin
    m_main = mreset();
    m_cont = mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_main = mreset();
        m_cont = mreset();
      end else begin
        m_main = mstep(m_main, start, in_v);
        m_cont = mstep(m_cont, 1'b1, in_c);
      end
    end
  end

  // Compare process, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check_dut("main", m_main, bus.sel, bus.busy, bus.done, bus.sample, ch_main);
      check_dut("cont", m_cont, bus_c.sel, bus_c.busy, bus_c.done, bus_c.sample, ch_cont);
      if (bus.done) done_cnt++;
      if (!rst_n) begin
        last_c = -1;
      end else if (bus_c.done) begin
        if (last_c >= 0) chk("cont.period", 32'(cyc - last_c), 32'd17);
        last_c = cyc;
      end
    end
  end

  // Continuous scanner sees a new random input vector every clock.
  initial begin
    forever begin
      @(negedge clk);
      in_c = 4'($urandom);
    end
  end

  task automatic sweep(input logic [3:0] a, input int chg_at, input logic [3:0] b,
                       input int pulse_at, input bit noise, output int n);
    in_v = a;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == chg_at) in_v = b;
      if (n == pulse_at) start = 1'b1;
      if (noise && $urandom_range(3) == 0) in_v = 4'($urandom);
      if (noise && n < 14 && $urandom_range(7) == 0) start = 1'b1;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'd16);
  endtask

  initial begin
    int n;
    int d0;
    #1;
    check_reset_now();
    #20;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single input high.
    sweep(4'b1000, -1, 4'b0, -1, 1'b0, n);
    chk("t2.sample", 32'(bus.sample), 32'h8);
    chk("t2.model", 32'(m_main.sample), 32'h8);

    // Input changes after the sel=1 capture.
    sweep(4'b0111, 8, 4'b1101, -1, 1'b0, n);
    chk("t3.sample", 32'(bus.sample), 32'hF);

    // Start during SCAN is not queued.
    d0 = done_cnt;
    sweep(4'($urandom), -1, 4'b0, 5, 1'b0, n);
    repeat (20) @(negedge clk);
    chk("t4.done_count", 32'(done_cnt - d0), 32'd1);
    chk("t4.idle", 32'(bus.busy), 32'd0);

    // Reset mid-sweep while sel=2.
    in_v = 4'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6.sel_before", 32'(bus.sel), 32'd2);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_reset_now();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("t6.no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6.sample", 32'(bus.sample), 32'd0);
    sweep(4'b0010, -1, 4'b0, -1, 1'b0, n);
    chk("t6.after", 32'(bus.sample), 32'h2);

`ifdef MUX_SCAN_CHANGE_EN
    sweep(4'b1110, -1, 4'b0, -1, 1'b0, n);
    sweep(4'b0111, -1, 4'b0, -1, 1'b0, n);
    chk("t7.change", 32'(bus.change), 32'h9);
`endif

    // Randomized sweeps with input churn and ignored starts.
    for (int i = 0; i < 10; i++) begin
      sweep(4'($urandom), -1, 4'b0, -1, 1'b1, n);
      n = 0;
      while (bus.busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rand.idle", 32'(bus.busy), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
